csla_pipe: RTL and testbench
============================

# csla_pipe

- Parametrised, pipelined carry-select adder.
- Generalises the fixed 16-bit combinational carry-select adder to any width, block size and pipeline depth.
- Adds valid/ready handshaking, back-pressure, a signed-overflow flag and an optional subtract mode.
- Sits in the datapath wherever wide additions must close timing at high clock rates, accepting one operand pair per cycle.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES*BLOCK.
- BLOCK, 4: carry-select block width; each block computes sums for carry-in 0 and 1 and muxes on the real carry.
- STAGES, 2: pipeline register stages; each stage adds WIDTH/STAGES bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  subtract request; ignored unless CSLA_PIPE_SUB_EN is defined.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB.
- ovf  output  1  signed overflow: operand sign bits (after sub inversion) equal and sum sign differs.

## Operation
- Stage k (0..STAGES-1) adds bit slice [(k+1)*W/S-1 : k*W/S], using the registered carry from stage k-1.
  - Stage 0 takes cin.
- Higher slices of a/b travel down the pipeline unmodified (operand skew).
- Lower result slices travel down the pipeline (de-skew), so sum is assembled whole at the last stage.
- A valid bit per stage tracks occupancy.
- Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - With stall low, all stages advance every cycle; bubbles (in_valid=0) propagate as valid=0.
  - With stall high, every stage register holds; data is never dropped or duplicated.
- Arithmetic: {cout,sum} = a + b + cin, all unsigned, no truncation beyond WIDTH+1 bits.
- Transfer in occurs on in_valid & in_ready; transfer out on out_valid & out_ready.
- Reset (async, any time, including mid-stream): all valid bits 0, sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 combinationally once reset deasserts. In-flight operations are discarded.
- Simultaneous in/out transfer with a full pipeline is legal and sustains 1 result/cycle.

## Timing
- Latency: an operand pair accepted on edge n appears with out_valid=1 after edge n+STAGES, absent stall.
- Each held stall cycle adds exactly one cycle of latency to every in-flight item.
- Throughput: 1 op/cycle when out_ready is held high.
- in_ready depends combinationally on out_ready; no other combinational input-to-output paths.
- Critical path per stage: one BLOCK ripple plus (W/S)/BLOCK carry-select muxes.

## Configuration
- CSLA_PIPE_SUB_EN defined:
  - sub=1 computes a + ~b + 1, i.e. a - b; cin is ignored in this mode.
  - cout = 1 means no borrow (a >= b unsigned).
  - ovf uses the inverted b sign.
  - sub is captured with the operands and is pipelined per item.
- CSLA_PIPE_SUB_EN undefined:
  - sub is ignored; always a + b + cin.
  - No inversion logic is synthesised.

## Test plan
- Reset, then a=25, b=32, cin=0, one beat, out_ready=1 -> after 2 cycles: sum=57, cout=0, ovf=0, out_valid high for exactly 1 cycle.
- a=32'hFFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, ovf=0; a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, ovf=1, cout=0.
- Stream pairs (64,64), (123,50), (22,234), (13,0), (0,0), one per cycle -> results 128, 173, 256, 13, 0 on 5 consecutive cycles starting 2 cycles after the first accept.
- Same stream with out_ready low for 3 cycles after the first result -> in_ready low those 3 cycles, first result held stable, then all 5 results in order with none lost.
- Assert rst_n low for 1 cycle while 2 items are in flight -> out_valid=0, sum=0 immediately; no stale results appear after release.
- With CSLA_PIPE_SUB_EN: a=100, b=58, sub=1 -> sum=42, cout=1; a=5, b=7, sub=1 -> sum=32'hFFFF_FFFE, cout=0. Without the macro, a=5, b=7, sub=1 -> sum=12.

Source files
------------

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder with valid/ready flow control and a global stall.
// Define CSLA_PIPE_SUB_EN to enable the per-item subtract mode (a - b when sub=1).
module csla_pipe #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW   = WIDTH / STAGES;
   localparam int NB   = SW / BLOCK;
   localparam int LAST = STAGES - 1;

   // Handshake: a beat moves in on in_valid & in_ready and out on
   // out_valid & out_ready; the only stall source is an unconsumed result,
   // which freezes every rank at once so nothing is dropped or duplicated.

   function automatic logic [SW:0] csla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
      logic [SW-1:0] s;
      logic          c;
      logic [BLOCK:0] s0;
      logic [BLOCK:0] s1;
      s = '0;
      c = ci;
      for (int i = 0; i < NB; i++) begin
         s0 = {1'b0, x[i*BLOCK +: BLOCK]} + {1'b0, y[i*BLOCK +: BLOCK]};
         s1 = {1'b0, x[i*BLOCK +: BLOCK]} + {1'b0, y[i*BLOCK +: BLOCK]}
              + {{BLOCK{1'b0}}, 1'b1};
         s[i*BLOCK +: BLOCK] = c ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
         c = c ? s1[BLOCK] : s0[BLOCK];
      end
      return {c, s};
   endfunction

   function automatic logic [WIDTH-1:0] keep_above(input int k);
      logic [WIDTH-1:0] m;
      m = '1;
      return m << ((k + 1) * SW);
   endfunction

   // Rank k holds the operands and carry entering adder stage k; rank
   // STAGES is the output rank.
   logic [STAGES:0]                 v_q;
   logic [STAGES:0]                 c_q;
   logic [STAGES-1:0][WIDTH-1:0]    a_q;
   logic [STAGES-1:0][WIDTH-1:0]    b_q;
   logic [STAGES-1:0][WIDTH-1:0]    s_q;
   logic                            ovf_q;

   logic [STAGES-1:0][SW:0]         slice_r;
   logic [STAGES-1:0][WIDTH-1:0]    s_nxt;
   logic                            ovf_nxt;
   logic [WIDTH-1:0]                b_in;
   logic                            c_in;
   logic                            stall;

`ifdef CSLA_PIPE_SUB_EN
   assign b_in = sub ? ~b : b;
   assign c_in = sub | cin;
   logic unused_bits;
   assign unused_bits = ^{a_q[LAST], b_q[LAST]};
`else
   assign b_in = b;
   assign c_in = cin;
   logic unused_bits;
   assign unused_bits = ^{a_q[LAST], b_q[LAST], sub};
`endif

   assign stall     = v_q[STAGES] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v_q[STAGES];
   assign sum       = s_q[LAST];
   assign cout      = c_q[STAGES];
   assign ovf       = ovf_q;

   always_comb begin
      s_nxt[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         s_nxt[k] = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice_r[k] = csla_slice(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], c_q[k]);
         s_nxt[k][k*SW +: SW] = slice_r[k][SW-1:0];
      end
      ovf_nxt = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                (slice_r[LAST][SW-1] != a_q[LAST][WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         ovf_q <= 1'b0;
      end else if (!stall) begin
         v_q[0] <= in_valid;
         if (in_valid) begin
            a_q[0] <= a;
            b_q[0] <= b_in;
            c_q[0] <= c_in;
         end
         for (int k = 0; k < STAGES; k++) begin
            v_q[k+1] <= v_q[k];
            if (v_q[k]) begin
               c_q[k+1] <= slice_r[k][SW];
               s_q[k]   <= s_nxt[k];
            end
         end
         // Consumed low slices are cleared as operands move down, so only
         // the still-needed high bits cost storage.
         for (int k = 1; k < STAGES; k++) begin
            if (v_q[k-1]) begin
               a_q[k] <= a_q[k-1] & keep_above(k - 1);
               b_q[k] <= b_q[k-1] & keep_above(k - 1);
            end
         end
         if (v_q[LAST]) begin
            ovf_q <= ovf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_csla_pipe.sv
// Directed and randomized checks of csla_pipe against a latency/stall-aware
// arithmetic reference model.
module tb_csla_pipe;

   localparam int W = 32;
   localparam int S = 2;
`ifdef CSLA_PIPE_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   csla_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Expected {ovf, cout, sum} per accepted item, with cycles left until visible.
   logic [W+1:0] exp_q[$];
   int           rem_q[$];
   logic [W-1:0] got_q[$];
   int           n_vec = 0;
   int           n_err = 0;

   logic [W-1:0] sa[5] = '{32'd64, 32'd123, 32'd22, 32'd13, 32'd0};
   logic [W-1:0] sb[5] = '{32'd64, 32'd50, 32'd234, 32'd0, 32'd0};
   logic [W-1:0] sr[5] = '{32'd128, 32'd173, 32'd256, 32'd13, 32'd0};

   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sbt);
      logic [W-1:0] yy;
      logic         c;
      logic [W:0]   t;
      logic         o;
      yy = (sbt && SUB_EN) ? ~y : y;
      c  = (sbt && SUB_EN) ? 1'b1 : ci;
      t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
      o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return {o, t};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sbt, input logic ordy, output logic acc);
      logic ov;
      logic st;
      in_valid  = iv;
      a         = x;
      b         = y;
      cin       = ci;
      sub       = sbt;
      out_ready = ordy;
      #1;
      ov  = (rem_q.size() > 0) && (rem_q[0] == 0);
      st  = ov & ~ordy;
      acc = iv & ~st;
      check("out_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, ov});
      check("in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, ~st});
      if (ov) begin
         check("result", {ovf, cout, sum}, exp_q[0]);
         if (ordy) got_q.push_back(sum);
      end
      @(posedge clk);
      if (!st) begin
         if (ov) begin
            void'(exp_q.pop_front());
            void'(rem_q.pop_front());
         end
         foreach (rem_q[j]) rem_q[j]--;
         if (acc) begin
            exp_q.push_back(model(x, y, ci, sbt));
            rem_q.push_back(S);
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   initial begin
      logic         acc;
      int           idx;
      logic [W-1:0] ca;
      logic [W-1:0] cb;
      logic         cc;
      logic         cs;
      logic         cv;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
      check("rst_sum", {2'b00, sum}, '0);
      check("rst_cout", {{(W+1){1'b0}}, cout}, '0);
      check("rst_ovf", {{(W+1){1'b0}}, ovf}, '0);
      check("rst_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});

      // Single beat 25 + 32
      step(1'b1, 32'd25, 32'd32, 1'b0, 1'b0, 1'b1, acc);
      idle(2);
      check("beat_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
      check("beat_res", {ovf, cout, sum}, {1'b0, 1'b0, 32'd57});
      idle(2);

      // Carry-out and signed overflow corners
      step(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      idle(1);
      check("wrap_res", {ovf, cout, sum}, {1'b0, 1'b1, 32'h0000_0000});
      idle(1);
      check("ovf_res", {ovf, cout, sum}, {1'b1, 1'b0, 32'h8000_0000});
      idle(2);

      // Back-to-back stream
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step(1'b1, sa[i], sb[i], 1'b0, 1'b0, 1'b1, acc);
         else       idle(1);
         if (i >= 2) begin
            check("stream_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
            check("stream_sum", {2'b00, sum}, {2'b00, sr[i-2]});
         end
      end
      idle(2);

      // Same stream with three cycles of back-pressure after the first result
      got_q.delete();
      idx = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (idx < 5) step(1'b1, sa[idx], sb[idx], 1'b0, 1'b0, !(cyc >= 3 && cyc <= 5), acc);
         else         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         if (acc) idx++;
      end
      check("stall_count", {{(W-30){1'b0}}, 32'(got_q.size())}, {{(W-30){1'b0}}, 32'd5});
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size()) check("stall_order", {2'b00, got_q[i]}, {2'b00, sr[i]});
      end

      // Reset with two items in flight
      step(1'b1, 32'd1000, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'd2000, 32'd2, 1'b0, 1'b0, 1'b1, acc);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {{(W+1){1'b0}}, out_valid}, '0);
      check("mid_rst_sum", {2'b00, sum}, '0);
      check("mid_rst_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
      exp_q.delete();
      rem_q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(4);

      // Subtract request
      step(1'b1, 32'd100, 32'd58, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, acc);
      idle(1);
      check("sub_a", {1'b0, cout, sum},
            SUB_EN ? {2'b01, 32'd42} : {2'b00, 32'd158});
      idle(1);
      check("sub_b", {1'b0, cout, sum},
            SUB_EN ? {2'b00, 32'hFFFF_FFFE} : {2'b00, 32'd12});
      idle(2);

      // Randomized traffic with random bubbles and back-pressure
      cv = 1'b0;
      ca = '0;
      cb = '0;
      cc = 1'b0;
      cs = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!cv) begin
            cv = ($urandom_range(0, 3) != 0);
            ca = pick();
            cb = pick();
            cc = 1'($urandom_range(0, 1));
            cs = 1'($urandom_range(0, 1));
         end
         step(cv, ca, cb, cc, cs, ($urandom_range(0, 3) != 0), acc);
         if (acc || !cv) cv = 1'b0;
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
      check("drain", {{(W-30){1'b0}}, 32'(exp_q.size())}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
